// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DISCARD  = 2'd2
  } ifq_state_e;

  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic int ifq_ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of {instr, pc_incr} entries. Head is registered storage, visible one cycle after push.
// Flush wins over push and pop; pop when empty is ignored; the caller never pushes into a full buffer.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = ifq_ptr_w(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [63:0]   i_push_dat,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic          o_vld,
  output logic [63:0]   o_head_dat,
  output logic [CW-1:0] o_count
);

  logic [63:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop = i_pop && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_vld      = (r_count != '0);
  assign o_head_dat = o_vld ? r_mem[r_rd_ptr] : '0;
  assign o_count    = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch FSM with a prefetch FIFO feeding IF/ID. Ack at edge N shows at the head after edge N (no bypass).
// Fetching pauses when the FIFO would be full; a redirect flushes and abandons any in-flight word.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   deq_ready,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc_incr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = ifq_ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  ifq_state_e    r_state;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_fetch_pc;

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_vld;
  logic [63:0]   w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  logic [31:0]   w_redir_pc;
  logic [31:0]   w_next_pc;

  assign w_ack         = r_mem_req && mem_ack;
  assign w_redir_pc    = redirect_pc & ~32'h3;
  assign w_next_pc     = r_mem_addr + PC_STEP;
  assign w_push        = (r_state == WAIT_ACK) && w_ack && !redirect_valid;
  assign w_pop         = w_vld && deq_ready;
  assign w_count_after = w_count + CW'(1) - CW'(w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
          end else if (w_count < FULL) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
            r_state    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            if (w_ack) begin
              r_mem_req <= 1'b0;
              r_state   <= IDLE;
            end else begin
              // Request stays on the bus until the memory answers; its data is dropped.
              r_state <= DISCARD;
            end
          end else if (w_ack) begin
            r_fetch_pc <= w_next_pc;
            if (w_count_after < FULL) begin
              r_mem_addr <= w_next_pc;
            end else begin
              r_mem_req <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (redirect_valid) r_fetch_pc <= w_redir_pc;
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat ({mem_rdata, w_next_pc}),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_vld      (w_vld),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign out_valid   = w_vld;
  assign out_instr   = w_vld ? w_head[63:32] : NOP_INSTR;
  assign out_pc_incr = w_vld ? w_head[31:0] : 32'h0;
  assign count       = w_count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: per-cycle vector table, hand-written redirect/reset sequences,
// and a scoreboard fed at each accepted memory ack and drained at each dequeue.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        deq_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc_incr;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;
  int lat     = 0;
  int lat_cnt = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_incr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_addr   = RESET_PC;
  bit          discarding = 1'b0;

  typedef struct {
    bit          do_rst;
    bit          deq;
    bit          exp_req;
    logic [31:0] exp_addr;
    int          exp_cnt;
    logic [31:0] exp_pcinc;
  } vec_t;

  vec_t vt[16];

  ifetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc_incr    (out_pc_incr),
    .count          (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // Instruction memory: answers after 'lat' idle cycles of an outstanding request.
  always_comb begin
    mem_ack   = mem_req && (lat_cnt >= lat);
    mem_rdata = mem_ack ? mw(mem_addr) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  task automatic tmo(input string name);
    n_total++;
    $display("FAIL %s: got no DUT event, want one within the cycle bound at t=%0t", name, $time);
  endtask

  // Scoreboard: decide at each negedge what the coming edge will push/pop.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_addr   = RESET_PC;
      discarding = 1'b0;
    end else begin
      chk("count_vs_model", 32'(count), 32'(sb.size()));
      chk("valid_vs_model", 32'(out_valid), (sb.size() != 0) ? 32'd1 : 32'd0);
      if (!out_valid) begin
        chk("empty_instr", out_instr, 32'h0);
        chk("empty_pc_incr", out_pc_incr, 32'h0);
      end
      if (redirect_valid) begin
        if (mem_req && !mem_ack) discarding = 1'b1;
        else if (mem_req && mem_ack) discarding = 1'b0;
        sb.delete();
        exp_addr = redirect_pc & ~32'h3;
      end else begin
        if (out_valid && deq_ready) begin
          if (sb.size() == 0) begin
            chk("pop_unexpected", out_pc_incr, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("head_instr", out_instr, e.instr);
            chk("head_pc_incr", out_pc_incr, e.pc_incr);
          end
        end
        if (mem_req && mem_ack) begin
          if (discarding) begin
            discarding = 1'b0;
          end else begin
            exp_t e;
            chk("fetch_addr", mem_addr, exp_addr);
            e.instr   = mw(exp_addr);
            e.pc_incr = exp_addr + 32'd4;
            sb.push_back(e);
            exp_addr = exp_addr + 32'd4;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_req_at(input logic [31:0] a, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == a) found = 1'b1;
    end
    if (!found) tmo(name);
  endtask

  task automatic wait_ack(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_ack) found = 1'b1;
    end
    if (!found) tmo(name);
  endtask

  task automatic wait_new_req(input logic [31:0] a, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_req) found = 1'b1;
    end
    if (!found) tmo(name);
    else chk(name, mem_addr, a);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1);
  end

  initial begin
    // Rows: do_rst, deq, exp_req, exp_addr, exp_cnt, exp_pcinc (head)
    vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 0, 32'h00};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1, 32'h04};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1, 32'h08};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1, 32'h0C};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1, 32'h10};
    vt[5]  = '{1'b1, 1'b0, 1'b1, 32'h00, 0, 32'h00};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1, 32'h04};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h08, 2, 32'h04};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 3, 32'h04};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h0C, 4, 32'h04};
    vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0C, 4, 32'h04};
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0C, 4, 32'h04};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0C, 3, 32'h08};
    vt[13] = '{1'b0, 1'b1, 1'b1, 32'h10, 2, 32'h0C};
    vt[14] = '{1'b0, 1'b1, 1'b1, 32'h14, 2, 32'h10};
    vt[15] = '{1'b0, 1'b1, 1'b1, 32'h18, 2, 32'h14};

    // Reset values while rst is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc_incr", out_pc_incr, 32'h0);

    // 0-wait streaming, then DEPTH saturation with deq_ready low and resume
    lat = 0;
    for (int r = 0; r < 16; r++) begin
      if (vt[r].do_rst) do_reset();
      deq_ready = vt[r].deq;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_mem_req", r), 32'(mem_req), 32'(vt[r].exp_req));
      chk($sformatf("vec%0d_mem_addr", r), mem_addr, vt[r].exp_addr);
      chk($sformatf("vec%0d_count", r), 32'(count), 32'(vt[r].exp_cnt));
      chk($sformatf("vec%0d_out_valid", r), 32'(out_valid), (vt[r].exp_cnt != 0) ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_pc_incr", r), out_pc_incr, vt[r].exp_pcinc);
      chk($sformatf("vec%0d_instr", r), out_instr,
          (vt[r].exp_cnt != 0) ? mw(vt[r].exp_pcinc - 32'd4) : 32'h0);
    end

    // 3-cycle memory: redirect one cycle after the request at 0x8
    do_reset();
    lat = 3;
    deq_ready = 1'b1;
    wait_req_at(32'h8, "lat3_req_at_8");
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    begin
      bit acked = 1'b0;
      for (int i = 0; i < 20 && !acked; i++) begin
        @(negedge clk);
        chk("discard_mem_req", 32'(mem_req), 32'd1);
        chk("discard_mem_addr", mem_addr, 32'h8);
        chk("discard_count", 32'(count), 32'd0);
        if (mem_ack) acked = 1'b1;
      end
      if (!acked) tmo("discard_ack");
    end
    wait_new_req(32'h100, "after_discard_addr");
    chk("after_discard_count", 32'(count), 32'd0);
    repeat (16) @(posedge clk);

    // Redirect coincident with ack and deq_ready (low bits of redirect_pc ignored)
    do_reset();
    lat = 0;
    deq_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    chk("redir_ack_valid", 32'(out_valid), 32'd0);
    chk("redir_ack_count", 32'(count), 32'd0);
    chk("redir_ack_mem_req", 32'(mem_req), 32'd0);
    chk("redir_ack_instr", out_instr, 32'h0);
    @(posedge clk);
    #1;
    chk("redir_ack_req", 32'(mem_req), 32'd1);
    chk("redir_ack_addr", mem_addr, 32'h40);
    chk("redir_ack_no_stale", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("redir_ack_head_pc", out_pc_incr, 32'h44);
    chk("redir_ack_head_instr", out_instr, mw(32'h40));
    repeat (6) @(posedge clk);

    // Two redirects during DISCARD: the last one wins
    do_reset();
    lat = 4;
    deq_ready = 1'b1;
    wait_req_at(32'h4, "lat4_req_at_4");
    @(posedge clk);
    #1 redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(posedge clk);
    #1 redirect_pc = 32'h300;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    chk("two_redir_hold_addr", mem_addr, 32'h4);
    wait_ack("two_redir_ack");
    wait_new_req(32'h300, "two_redir_next_addr");
    repeat (24) @(posedge clk);

    // Asynchronous reset in the middle of a request with two entries queued
    do_reset();
    lat = 2;
    deq_ready = 1'b0;
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (mem_req && count == 3'd2) hit = 1'b1;
      end
      if (!hit) tmo("pre_reset_count2");
    end
    #1 rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(mem_req), 32'd0);
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_out_instr", out_instr, 32'h0);
    chk("async_rst_mem_addr", mem_addr, RESET_PC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    deq_ready = 1'b1;
    wait_new_req(RESET_PC, "post_rst_first_addr");
    repeat (12) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end with a small prefetch FIFO, directly upstream of the IF/ID pipeline register.
- Replaces the combinational PC/instruction-memory path with a request/acknowledge fetch port to a variable-latency instruction memory.
- Buffers fetched words and presents {instruction, PC+4} to IF/ID.
- Accepts stalls from the hazard unit and redirects from branch/jump resolution in decode.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_req  out  1  fetch request to instruction memory (registered)
mem_addr  out  32  fetch word address (registered, word aligned)
mem_ack  in  1  memory has returned mem_rdata for the current request
mem_rdata  in  32  instruction word; valid only when mem_ack=1
redirect_valid  in  1  taken branch/jump: flush and refetch
redirect_pc  in  32  new fetch address; bits[1:0] ignored, treated as 0
deq_ready  in  1  IF/ID enable; head is consumed when out_valid and deq_ready are both 1
out_valid  out  1  FIFO head valid
out_instr  out  32  head instruction; 32'h0 (nop) when empty
out_pc_incr  out  32  head fetch address + 4; 32'h0 when empty
count  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

Behaviour:
- Reset (asynchronous, effective immediately):
  - mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC.
  - FIFO empty: count=0, out_valid=0, out_instr=0, out_pc_incr=0.
  - State = IDLE. Reset mid-request drops mem_req at once; the memory must tolerate abandonment.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT_ACK: mem_req=1, response wanted.
  - DISCARD: mem_req=1, response will be dropped.
- Memory handshake:
  - While mem_req=1, mem_addr holds stable until the cycle mem_ack=1.
  - At most one request is outstanding.
  - mem_ack with mem_req=0 is ignored.
- IDLE transitions:
  - If redirect_valid=0 and count<DEPTH: next cycle mem_req=1, mem_addr=fetch_pc, go to WAIT_ACK.
  - Otherwise stay in IDLE.
- WAIT_ACK transitions:
  - mem_ack=1, redirect_valid=0:
    - Push {mem_rdata, mem_addr+4}; fetch_pc = mem_addr+4.
    - If (count after push and pop) < DEPTH: stay in WAIT_ACK, mem_addr = mem_addr+4 next cycle (back-to-back, one word per cycle with a 0-wait memory).
    - Else mem_req=0, go to IDLE.
  - mem_ack=0, redirect_valid=1: flush FIFO, fetch_pc=redirect_pc, go to DISCARD; mem_req/mem_addr unchanged.
  - mem_ack=1, redirect_valid=1: drop mem_rdata, flush, fetch_pc=redirect_pc, mem_req=0, go to IDLE.
- DISCARD transitions:
  - On mem_ack: drop data, mem_req=0, go to IDLE.
  - A redirect while in DISCARD overwrites fetch_pc; the last redirect wins.
- Overflow safety:
  - Issue requires count<DEPTH.
  - Only this block pushes, so occupancy cannot exceed DEPTH when the ack arrives.
- Latency: ack at edge N gives out_valid=1 after edge N. There is no bypass from mem_rdata to the outputs.
- Dequeue:
  - Pop on out_valid & deq_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Pop when empty has no effect.
- Redirect priority: redirect beats push and pop in the same cycle. FIFO empty next cycle, count=0.
- Pointers:
  - clog2(DEPTH)-bit read/write pointers wrap modulo DEPTH.
  - A separate count distinguishes full from empty.
- Arithmetic: all PC additions are modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Decomposition:
- Package ifq_pkg: state enum {IDLE, WAIT_ACK, DISCARD}, PC_STEP=4, NOP_INSTR=32'h0, pointer-width function.
- Sub-module ifq_fifo:
  - Parameterized circular buffer, 64-bit entries {instr, pc_incr}.
  - push/pop/flush/count interface with head outputs.
- The FSM and PC logic stay in ifetch_queue.

Test Plan:
- Reset, 0-wait memory (mem_ack=mem_req), deq_ready=1:
  - mem_addr sequence 0,4,8,C on consecutive cycles.
  - out_pc_incr 4,8,C,10; out_instr equals the returned words.
- deq_ready=0, DEPTH=4:
  - Exactly 4 acks; count saturates at 4; mem_req=0; no fifth request.
  - Raise deq_ready: one pop per cycle and fetching resumes at 0x10.
- 3-cycle-latency memory, redirect_valid pulse (redirect_pc=0x100) one cycle after a request at 0x8:
  - mem_addr holds 0x8 until ack; that word is dropped.
  - Next request is 0x100; count=0 meanwhile.
- Redirect coincident with mem_ack and deq_ready:
  - Data dropped, FIFO empty next cycle.
  - Next mem_addr=redirect_pc; no stale out_valid.
- Two redirects (0x200 then 0x300) during DISCARD:
  - After the ack, the next request is 0x300.
- rst asserted while mem_req=1 and count=2:
  - Outputs clear immediately (mem_req=0, out_valid=0, count=0).
  - First post-reset request is at RESET_PC.
